messbauer_diff_discriminator_counter: RTL and testbench
=======================================================

Name: messbauer_diff_discriminator_counter

Overview:
- Downstream consumer of the simulated differential-discriminator outputs (lower_threshold, upper_threshold).
- Classifies each impulse as accepted (lower crossed, upper never crossed) or rejected (upper crossed while lower high). Counts accepted impulses per velocity channel.
- On each channel-advance strobe, hands the closed channel's count to the spectrum store over a valid/ready interface.

Parameters:
- COUNTER_WIDTH, 16, width of per-channel accepted-impulse counter.
- CHANNEL_WIDTH, 9, width of channel index.
- CHANNELS, 512, channels per spectrum sweep; index wraps to 0 after CHANNELS-1.
- MAX_IMPULSE_DURATION, 32, aclk cycles; a lower_threshold pulse longer than this is discarded as stuck.

Ports:
- aclk, input, 1, system clock; all logic on rising edge.
- areset, input, 1, asynchronous active-high reset.
- lower_threshold, input, 1, asynchronous discriminator lower-level output.
- upper_threshold, input, 1, asynchronous discriminator upper-level output.
- channel, input, 1, asynchronous channel-advance signal; rising edge closes the current channel.
- count_data, output, COUNTER_WIDTH, accepted count of the closed channel.
- count_channel, output, CHANNEL_WIDTH, index of the closed channel.
- count_valid, output, 1, count_data/count_channel valid.
- count_ready, input, 1, consumer accepts when count_valid && count_ready.
- sweep_done, output, 1, one-cycle pulse when channel CHANNELS-1 closes.
- overrun, output, 1, sticky error flag; cleared only by areset.
- rejected_total, output, COUNTER_WIDTH, saturating count of rejected and stuck impulses since reset.

Behaviour:
- Reset: all outputs 0, channel index 0, counters 0, FSM in IDLE.
- Input synchronisation: lower_threshold, upper_threshold and channel each pass through a 2-FF synchroniser; all edge detection uses the synchronised signals. Minimum latency from pin edge to FSM reaction is 2 cycles.
- FSM states and transitions:
  - IDLE: sync lower rises -> PULSE; clear upper_seen and dur_cnt.
  - PULSE: dur_cnt increments each cycle. Sync upper high in any cycle sets upper_seen.
    - Sync lower falls with upper_seen=0 -> accepted; acc_cnt += 1, saturating at all-ones.
    - Sync lower falls with upper_seen=1 -> rejected; rejected_total += 1, saturating.
    - Either fall returns to IDLE.
    - dur_cnt == MAX_IMPULSE_DURATION with lower still high -> GUARD; rejected_total += 1.
  - GUARD: ignore everything until sync lower low -> IDLE.
- Upper-only activity (upper high while FSM in IDLE) is ignored.
- Channel close (sync channel rising edge):
  - acc_cnt and the current index are loaded into the output holding register; count_valid is set.
  - acc_cnt clears and the index increments, wrapping CHANNELS-1 -> 0. sweep_done pulses on the wrap cycle.
  - Channel close and an accepted impulse in the same cycle: the impulse counts into the closing channel, so the loaded value is acc_cnt+1 (saturated), and the new channel starts at 0.
  - An impulse in progress (PULSE) at channel close is not aborted; its result counts into the new channel.
- Output handshake:
  - count_valid holds, with count_data and count_channel stable, until count_valid && count_ready.
  - After the handshake, count_valid falls next cycle unless a new close occurs in that same cycle; in that case the holding register reloads and count_valid stays 1.
  - Channel close while count_valid=1 and count_ready=0: the holding register is overwritten with the new channel's data and overrun is set.
- Reset asserted mid-operation clears everything immediately. No partial count is emitted.

Test Plan:
- Channel of 16 impulses: 4 lower-only pulses (lower 3 cycles) and 12 pulses with upper 1 cycle inside lower; then a channel edge -> count_data=4, count_channel=0, rejected_total=12.
- count_ready held 0 across two channel edges carrying 5 then 7 accepted impulses -> overrun=1; held data is 7 with channel 1; after ready, count_valid drops.
- Lower held high 40 cycles, followed by one good pulse -> rejected_total+=1 (stuck impulse); the good pulse is accepted and acc_cnt=1.
- Accepted impulse finishes in the same cycle as the channel edge, with 2 prior accepted -> emitted count_data=3; next channel starts at 0.
- 512 channel edges with count_ready=1 -> sweep_done pulses once, on count_channel=511; next emitted count_channel=0.
- COUNTER_WIDTH=4, 20 accepted impulses in one channel -> count_data=15 (saturated); areset mid-pulse -> all outputs 0 and no count_valid.

Source files
------------

// File: rtl/messbauer_diff_discriminator_counter.sv
// Differential-discriminator impulse classifier and per-channel counter.
// Accepted impulses (lower crossed, upper never) are counted per velocity
// channel; each channel-advance rising edge hands the closed channel's count
// to the spectrum store over a valid/ready holding register.
module messbauer_diff_discriminator_counter #(
  parameter int unsigned COUNTER_WIDTH        = 16,
  parameter int unsigned CHANNEL_WIDTH        = 9,
  parameter int unsigned CHANNELS             = 512,
  parameter int unsigned MAX_IMPULSE_DURATION = 32
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     lower_threshold,
  input  logic                     upper_threshold,
  input  logic                     channel,
  output logic [COUNTER_WIDTH-1:0] count_data,
  output logic [CHANNEL_WIDTH-1:0] count_channel,
  output logic                     count_valid,
  input  logic                     count_ready,
  output logic                     sweep_done,
  output logic                     overrun,
  output logic [COUNTER_WIDTH-1:0] rejected_total
);

  localparam int unsigned DurWidth = $clog2(MAX_IMPULSE_DURATION + 1);
  localparam logic [DurWidth-1:0]      DurMax   = DurWidth'(MAX_IMPULSE_DURATION);
  localparam logic [CHANNEL_WIDTH-1:0] LastChan = CHANNEL_WIDTH'(CHANNELS - 1);
  localparam logic [COUNTER_WIDTH-1:0] CntMax   = '1;

  typedef enum logic [1:0] {StIdle, StPulse, StGuard} state_e;

  // Stage [1] is the synchronised level; stage [2] is its previous value for
  // edge detection.
  logic [2:0] lower_sync_q;
  logic [1:0] upper_sync_q;
  logic [2:0] chan_sync_q;

  state_e                   state_q;
  logic                     upper_seen_q;
  logic [DurWidth-1:0]      dur_cnt_q;
  logic [COUNTER_WIDTH-1:0] acc_cnt_q;
  logic [CHANNEL_WIDTH-1:0] chan_idx_q;

  logic                     lower_s, lower_rise, upper_s, chan_close;
  logic                     impulse_upper, accept_evt, reject_evt;
  logic [COUNTER_WIDTH-1:0] acc_inc, acc_now;

  // Two-flop synchronisers plus one history stage for edge detection.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      lower_sync_q <= '0;
      upper_sync_q <= '0;
      chan_sync_q  <= '0;
    end else begin
      lower_sync_q <= {lower_sync_q[1:0], lower_threshold};
      upper_sync_q <= {upper_sync_q[0], upper_threshold};
      chan_sync_q  <= {chan_sync_q[1:0], channel};
    end
  end

  // Impulse classification and accepted-count next value.
  always_comb begin
    lower_s       = lower_sync_q[1];
    lower_rise    = lower_sync_q[1] & ~lower_sync_q[2];
    upper_s       = upper_sync_q[1];
    chan_close    = chan_sync_q[1] & ~chan_sync_q[2];
    // Upper seen in the falling cycle itself still rejects the impulse.
    impulse_upper = upper_seen_q | upper_s;
    accept_evt    = 1'b0;
    reject_evt    = 1'b0;
    if (state_q == StPulse) begin
      if (!lower_s) begin
        accept_evt = ~impulse_upper;
        reject_evt = impulse_upper;
      end else begin
        reject_evt = (dur_cnt_q == DurMax);
      end
    end
    acc_inc = (acc_cnt_q == CntMax) ? acc_cnt_q : acc_cnt_q + 1'b1;
    acc_now = accept_evt ? acc_inc : acc_cnt_q;
  end

  // Impulse FSM: IDLE waits for a lower rise, PULSE times and watches upper,
  // GUARD swallows a stuck pulse until lower drops.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= StIdle;
      upper_seen_q <= 1'b0;
      dur_cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (lower_rise) begin
            state_q      <= StPulse;
            upper_seen_q <= 1'b0;
            dur_cnt_q    <= '0;
          end
        end
        StPulse: begin
          if (upper_s) upper_seen_q <= 1'b1;
          if (!lower_s) begin
            state_q <= StIdle;
          end else if (dur_cnt_q == DurMax) begin
            state_q <= StGuard;
          end else begin
            dur_cnt_q <= dur_cnt_q + 1'b1;
          end
        end
        StGuard: begin
          if (!lower_s) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Per-channel accepted count, channel index and saturating reject total.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      acc_cnt_q      <= '0;
      chan_idx_q     <= '0;
      rejected_total <= '0;
    end else begin
      acc_cnt_q <= chan_close ? '0 : acc_now;
      if (chan_close) begin
        chan_idx_q <= (chan_idx_q == LastChan) ? '0 : chan_idx_q + 1'b1;
      end
      if (reject_evt && rejected_total != CntMax) begin
        rejected_total <= rejected_total + 1'b1;
      end
    end
  end

  // Output holding register with valid/ready handshake and sticky overrun.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      count_data    <= '0;
      count_channel <= '0;
      count_valid   <= 1'b0;
      sweep_done    <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      sweep_done <= chan_close && (chan_idx_q == LastChan);
      if (chan_close) begin
        // An impulse accepted in the closing cycle belongs to the closing channel.
        count_data    <= acc_now;
        count_channel <= chan_idx_q;
        count_valid   <= 1'b1;
        if (count_valid && !count_ready) overrun <= 1'b1;
      end else if (count_valid && count_ready) begin
        count_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_messbauer_diff_discriminator_counter.sv
// Directed bench for messbauer_diff_discriminator_counter. A second instance
// with a 4-bit counter shares the stimulus to exercise saturation.
module tb_messbauer_diff_discriminator_counter;

  logic aclk = 1'b0;
  logic areset, lower_threshold, upper_threshold, channel, count_ready;

  logic [15:0] count_data, rejected_total;
  logic [8:0]  count_channel;
  logic        count_valid, sweep_done, overrun;

  logic [3:0]  count_data4, rejected_total4;
  logic [8:0]  count_channel4;
  logic        count_valid4, sweep_done4, overrun4;

  int total = 0;
  int bad   = 0;
  int sweep_cnt = 0;
  int sweep_ch  = -1;
  int base;

  always #5 aclk = ~aclk;

  messbauer_diff_discriminator_counter dut (
    .aclk           (aclk),
    .areset         (areset),
    .lower_threshold(lower_threshold),
    .upper_threshold(upper_threshold),
    .channel        (channel),
    .count_data     (count_data),
    .count_channel  (count_channel),
    .count_valid    (count_valid),
    .count_ready    (count_ready),
    .sweep_done     (sweep_done),
    .overrun        (overrun),
    .rejected_total (rejected_total)
  );

  messbauer_diff_discriminator_counter #(.COUNTER_WIDTH(4)) dut4 (
    .aclk           (aclk),
    .areset         (areset),
    .lower_threshold(lower_threshold),
    .upper_threshold(upper_threshold),
    .channel        (channel),
    .count_data     (count_data4),
    .count_channel  (count_channel4),
    .count_valid    (count_valid4),
    .count_ready    (count_ready),
    .sweep_done     (sweep_done4),
    .overrun        (overrun4),
    .rejected_total (rejected_total4)
  );

  always @(negedge aclk) begin
    if (sweep_done) begin
      sweep_cnt = sweep_cnt + 1;
      sweep_ch  = int'(count_channel);
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic pulse(input int len, input bit with_upper);
    lower_threshold = 1'b1;
    for (int i = 0; i < len; i++) begin
      upper_threshold = with_upper && (i == 1);
      tick();
    end
    lower_threshold = 1'b0;
    upper_threshold = 1'b0;
    repeat (4) tick();
  endtask

  task automatic pulses(input int n, input bit with_upper);
    for (int i = 0; i < n; i++) pulse(3, with_upper);
  endtask

  task automatic chan_edge();
    channel = 1'b1;
    repeat (3) tick();
    channel = 1'b0;
    repeat (3) tick();
  endtask

  task automatic handshake();
    count_ready = 1'b1;
    tick();
    count_ready = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    tick();
  endtask

  initial begin
    areset = 1'b1;
    lower_threshold = 1'b0;
    upper_threshold = 1'b0;
    channel = 1'b0;
    count_ready = 1'b0;
    repeat (2) tick();
    check("rst_valid", count_valid, 0);
    check("rst_data", count_data, 0);
    check("rst_chan", count_channel, 0);
    check("rst_overrun", overrun, 0);
    check("rst_sweep", sweep_done, 0);
    check("rst_rej", rejected_total, 0);
    areset = 1'b0;
    tick();

    // 4 clean pulses, 12 with upper inside lower.
    pulses(4, 1'b0);
    pulses(12, 1'b1);
    chan_edge();
    check("t1_valid", count_valid, 1);
    check("t1_data", count_data, 4);
    check("t1_chan", count_channel, 0);
    check("t1_rej", rejected_total, 12);
    handshake();
    check("t1_valid_drop", count_valid, 0);

    // Overrun: two closes with ready held low.
    do_reset();
    pulses(5, 1'b0);
    chan_edge();
    check("t2_data_a", count_data, 5);
    check("t2_overrun_a", overrun, 0);
    pulses(7, 1'b0);
    chan_edge();
    check("t2_overrun_b", overrun, 1);
    check("t2_data_b", count_data, 7);
    check("t2_chan_b", count_channel, 1);
    check("t2_valid_b", count_valid, 1);
    handshake();
    check("t2_valid_drop", count_valid, 0);

    // Stuck lower (40 cycles) then a good pulse.
    pulse(40, 1'b0);
    check("t3_rej_stuck", rejected_total, 1);
    pulse(3, 1'b0);
    chan_edge();
    check("t3_data", count_data, 1);
    check("t3_chan", count_channel, 2);
    check("t3_rej", rejected_total, 1);
    handshake();

    // Accepted fall coincides with channel close.
    pulses(2, 1'b0);
    lower_threshold = 1'b1;
    repeat (3) tick();
    lower_threshold = 1'b0;
    channel = 1'b1;
    repeat (3) tick();
    channel = 1'b0;
    repeat (3) tick();
    check("t4_data", count_data, 3);
    check("t4_chan", count_channel, 3);
    handshake();
    chan_edge();
    check("t4_next_data", count_data, 0);
    check("t4_next_chan", count_channel, 4);
    handshake();

    // Full sweep with ready held high.
    do_reset();
    base = sweep_cnt;
    count_ready = 1'b1;
    for (int i = 0; i < 512; i++) chan_edge();
    check("t5_sweep_cnt", sweep_cnt - base, 1);
    check("t5_sweep_ch", sweep_ch, 511);
    check("t5_valid_drop", count_valid, 0);
    chan_edge();
    check("t5_wrap_chan", count_channel, 0);
    check("t5_sweep_cnt2", sweep_cnt - base, 1);
    count_ready = 1'b0;

    // Saturation on the 4-bit instance, then reset mid-pulse.
    do_reset();
    pulses(20, 1'b0);
    chan_edge();
    check("t6_data16", count_data, 20);
    check("t6_data4_sat", count_data4, 15);
    check("t6_valid4", count_valid4, 1);
    lower_threshold = 1'b1;
    repeat (6) tick();
    areset = 1'b1;
    #1;
    check("t6_rst_valid", count_valid, 0);
    check("t6_rst_data", count_data, 0);
    check("t6_rst_valid4", count_valid4, 0);
    check("t6_rst_data4", count_data4, 0);
    check("t6_rst_rej4", rejected_total4, 0);
    check("t6_rst_overrun", overrun, 0);
    lower_threshold = 1'b0;
    repeat (3) tick();
    areset = 1'b0;
    repeat (6) tick();
    check("t6_post_valid", count_valid, 0);
    check("t6_post_valid4", count_valid4, 0);
    check("t6_post_rej", rejected_total, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
